// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core data bus.
// Byte stores to TXDATA are queued in a TX FIFO and serialised on uart_tx.
//
// Register window (16 bytes at BASE_ADDR, offset = mem_addr[3:2]):
//   0 TXDATA  W : push wdata[7:0] when wstrb[0]; reads 0
//   1 STATUS  R : {count @ bit 8, busy, fifo_empty, fifo_full}
//   2 DIV     RW: clk cycles per bit, [15:0]; write needs wstrb[1:0]=11, 0 -> 1
//   3 reserved
//
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   mem_wren/mem_rden  data-bus write/read strobes (read wins when both set)
//   mem_addr           byte address
//   mem_wdata/wstrb    write data and byte enables
//   mem_rdata          read data, registered, 1-cycle latency, holds otherwise
//   sel_hit            combinational window decode
//   uart_tx            serial line, idle high, registered
//   tx_drop            one-cycle pulse when a TXDATA write hits a full FIFO
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int unsigned CLK_DIV    = 868,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_wren,
  input  logic        mem_rden,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        sel_hit,
  output logic        uart_tx,
  output logic        tx_drop
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // Bus decode
  logic [1:0] off;
  logic       rd_acc, wr_acc, push_req, div_wr;
  logic       unused_bits;

  assign off      = mem_addr[3:2];
  assign sel_hit  = (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign rd_acc   = mem_rden & sel_hit;
  assign wr_acc   = mem_wren & sel_hit & ~mem_rden;
  assign push_req = wr_acc & (off == 2'd0) & mem_wstrb[0];
  assign div_wr   = wr_acc & (off == 2'd2) & (mem_wstrb[1:0] == 2'b11);
  assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:16], mem_wstrb[3:2]};

  // TX FIFO
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, push, pop;

  // full/empty come from pre-edge count, so a push to a full FIFO is dropped
  // even when the transmitter pops on the same edge.
  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign push  = push_req & ~full;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_wdata[7:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      tx_drop <= 1'b0;
    end else begin
      tx_drop <= push_req & full;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Registers and read path
  logic [15:0] div;
  logic [31:0] status, rdata_mux;
  state_t      state, state_n;

  always_comb begin
    status         = '0;
    status[0]      = full;
    status[1]      = empty;
    status[2]      = (state != IDLE);
    status[8 +: CW] = count;
  end

  always_comb begin
    rdata_mux = '0;
    case (off)
      2'd1:    rdata_mux = status;
      2'd2:    rdata_mux = {16'd0, div};
      default: rdata_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div       <= 16'(CLK_DIV);
      mem_rdata <= '0;
    end else begin
      if (div_wr) div <= (mem_wdata[15:0] == 16'd0) ? 16'd1 : mem_wdata[15:0];
      if (rd_acc) mem_rdata <= rdata_mux;
    end
  end

  // Transmit FSM
  logic [7:0]  shift_reg, shift_n;
  logic [15:0] bit_len, bit_len_n, cnt, cnt_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic        tx_n;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_len   <= '0;
      cnt       <= '0;
      bit_idx   <= '0;
      uart_tx   <= 1'b1;
    end else begin
      state     <= state_n;
      shift_reg <= shift_n;
      bit_len   <= bit_len_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      uart_tx   <= tx_n;
    end
  end

  // tx_n is the line level for the state being entered, so uart_tx comes
  // straight from a flop and changes exactly on the state transitions.
  always_comb begin
    state_n   = state;
    shift_n   = shift_reg;
    bit_len_n = bit_len;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    tx_n      = uart_tx;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (!empty) begin
          pop       = 1'b1;
          shift_n   = fifo_mem[rd_ptr];
          bit_len_n = div;
          cnt_n     = div - 16'd1;
          tx_n      = 1'b0;
          state_n   = START;
        end
      end
      START: begin
        if (cnt == '0) begin
          state_n   = DATA;
          cnt_n     = bit_len - 16'd1;
          bit_idx_n = '0;
          tx_n      = shift_reg[0];
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      DATA: begin
        if (cnt == '0) begin
          cnt_n = bit_len - 16'd1;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            shift_n   = {1'b0, shift_reg[7:1]};
            tx_n      = shift_reg[1];
          end
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      STOP: begin
        if (cnt == '0) begin
          state_n = IDLE;
          tx_n    = 1'b1;
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx (CLK_DIV=4, FIFO_DEPTH=16).
module tb_mmio_uart_tx;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_wren, mem_rden;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        sel_hit, uart_tx, tx_drop;

  int tests = 0;
  int errors = 0;

  localparam logic [31:0] A_TX  = 32'h1000_0000;
  localparam logic [31:0] A_ST  = 32'h1000_0004;
  localparam logic [31:0] A_DIV = 32'h1000_0008;
  localparam logic [31:0] A_RSV = 32'h1000_000C;

  mmio_uart_tx #(
    .BASE_ADDR (32'h1000_0000),
    .CLK_DIV   (4),
    .FIFO_DEPTH(16)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .mem_wren (mem_wren),
    .mem_rden (mem_rden),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata),
    .sel_hit  (sel_hit),
    .uart_tx  (uart_tx),
    .tx_drop  (tx_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        chk;
    logic [31:0] exp_rdata;
    logic        exp_hit;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic wr, logic rd, logic [31:0] addr, logic [31:0] wdata,
                              logic [3:0] wstrb, logic chk, logic [31:0] exp_rdata,
                              logic exp_hit);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb;
    v.chk = chk; v.exp_rdata = exp_rdata; v.exp_hit = exp_hit;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected line level k cycles after the frame's start edge (k >= 1).
  function automatic logic exp_line(input logic [7:0] b, input int k, input int len);
    int seg;
    seg = (k - 1) / len;
    if (seg == 0) return 1'b0;
    if (seg <= 8) return b[seg-1];
    return 1'b1;
  endfunction

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    mem_addr = a; mem_wdata = d; mem_wstrb = s; mem_wren = 1'b1;
    @(posedge clk); #1;
    mem_wren = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    mem_addr = a; mem_rden = 1'b1;
    @(posedge clk); #1;
    mem_rden = 1'b0;
    d = mem_rdata;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run exceeded time limit at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;

    // Register-access vectors: wr, rd, addr, wdata, wstrb, chk, exp_rdata, exp_hit
    vecs.push_back(mk(0, 1, A_ST,  32'h0,         4'h0, 1, 32'h0000_0002, 1));
    vecs.push_back(mk(0, 1, A_DIV, 32'h0,         4'h0, 1, 32'h0000_0004, 1));
    vecs.push_back(mk(0, 1, A_TX,  32'h0,         4'h0, 1, 32'h0000_0000, 1));
    vecs.push_back(mk(0, 1, A_RSV, 32'h0,         4'h0, 1, 32'h0000_0000, 1));
    vecs.push_back(mk(1, 0, A_DIV, 32'h0,         4'hF, 0, 32'h0,         1));
    vecs.push_back(mk(0, 1, A_DIV, 32'h0,         4'h0, 1, 32'h0000_0001, 1));
    vecs.push_back(mk(1, 0, A_DIV, 32'h0000_0042, 4'h1, 0, 32'h0,         1));
    vecs.push_back(mk(0, 1, A_DIV, 32'h0,         4'h0, 1, 32'h0000_0001, 1));
    vecs.push_back(mk(1, 0, A_DIV, 32'h0000_0042, 4'h2, 0, 32'h0,         1));
    vecs.push_back(mk(0, 1, A_DIV, 32'h0,         4'h0, 1, 32'h0000_0001, 1));
    vecs.push_back(mk(1, 0, A_DIV, 32'hABCD_1234, 4'h3, 0, 32'h0,         1));
    vecs.push_back(mk(0, 1, 32'h1000_000A, 32'h0, 4'h0, 1, 32'h0000_1234, 1));
    vecs.push_back(mk(1, 0, A_RSV, 32'h0000_FFFF, 4'hF, 0, 32'h0,         1));
    vecs.push_back(mk(0, 1, A_RSV, 32'h0,         4'h0, 1, 32'h0000_0000, 1));
    vecs.push_back(mk(0, 1, A_DIV, 32'h0,         4'h0, 1, 32'h0000_1234, 1));
    vecs.push_back(mk(1, 0, 32'h1000_0018, 32'h7, 4'hF, 0, 32'h0,         0));
    vecs.push_back(mk(0, 1, 32'h1000_0018, 32'h0, 4'h0, 1, 32'h0000_1234, 0));
    vecs.push_back(mk(0, 1, A_DIV, 32'h0,         4'h0, 1, 32'h0000_1234, 1));
    vecs.push_back(mk(1, 0, 32'h1000_0010, 32'h55, 4'hF, 0, 32'h0,        0));
    vecs.push_back(mk(1, 1, A_TX,  32'h0000_0099, 4'hF, 1, 32'h0000_0000, 1));
    vecs.push_back(mk(0, 1, A_ST,  32'h0,         4'h0, 1, 32'h0000_0002, 1));
    vecs.push_back(mk(1, 0, A_DIV, 32'h0000_0004, 4'hF, 0, 32'h0,         1));
    vecs.push_back(mk(0, 1, A_DIV, 32'h0,         4'h0, 1, 32'h0000_0004, 1));
    vecs.push_back(mk(1, 0, A_TX,  32'h0000_0077, 4'hE, 0, 32'h0,         1));
    vecs.push_back(mk(0, 1, A_ST,  32'h0,         4'h0, 1, 32'h0000_0002, 1));

    // Reset state
    resetn = 1'b0; mem_wren = 1'b0; mem_rden = 1'b0;
    mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    #12;
    check("reset_rdata", mem_rdata, 32'h0);
    check("reset_uart_tx", {31'd0, uart_tx}, 32'h1);
    check("reset_tx_drop", {31'd0, tx_drop}, 32'h0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // Table-driven register accesses
    foreach (vecs[i]) begin
      mem_wren  = vecs[i].wr;
      mem_rden  = vecs[i].rd;
      mem_addr  = vecs[i].addr;
      mem_wdata = vecs[i].wdata;
      mem_wstrb = vecs[i].wstrb;
      #1;
      check($sformatf("sel_hit[%0d]", i), {31'd0, sel_hit}, {31'd0, vecs[i].exp_hit});
      @(posedge clk); #1;
      mem_wren = 1'b0;
      mem_rden = 1'b0;
      if (vecs[i].chk) check($sformatf("rdata[%0d]", i), mem_rdata, vecs[i].exp_rdata);
      check($sformatf("idle_line[%0d]", i), {30'd0, tx_drop, uart_tx}, 32'h1);
    end

    // Single frame 0x55 at DIV=4
    bus_write(A_TX, 32'h55, 4'h1);
    check("frame55_pre", {31'd0, uart_tx}, 32'h1);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      check($sformatf("frame55_k%0d", k), {31'd0, uart_tx}, {31'd0, exp_line(8'h55, k, 4)});
    end
    bus_read(A_ST, rd);
    check("frame55_busy_last", rd, 32'h0000_0006);
    bus_read(A_ST, rd);
    check("frame55_idle", rd, 32'h0000_0002);

    // Overflow burst at DIV=100
    bus_write(A_DIV, 32'd100, 4'h3);
    mem_addr = A_TX; mem_wstrb = 4'hF; mem_wren = 1'b1;
    for (int i = 0; i < 18; i++) begin
      mem_wdata = 32'h30 + i;
      @(posedge clk); #1;
      check($sformatf("burst_drop_%0d", i), {31'd0, tx_drop}, (i == 17) ? 32'h1 : 32'h0);
    end
    mem_wren = 1'b0;
    @(posedge clk); #1;
    check("burst_drop_after", {31'd0, tx_drop}, 32'h0);
    bus_read(A_ST, rd);
    check("burst_status", rd, 32'h0000_1005);
    repeat (982) @(posedge clk);
    #1;
    check("burst_stop_bit", {31'd0, uart_tx}, 32'h1);
    mem_addr = A_TX; mem_wstrb = 4'hF; mem_wdata = 32'hEE; mem_wren = 1'b1;
    @(posedge clk); #1;
    check("popedge_drop", {31'd0, tx_drop}, 32'h1);
    check("popedge_start", {31'd0, uart_tx}, 32'h0);
    mem_wdata = 32'hEF;
    @(posedge clk); #1;
    mem_wren = 1'b0;
    check("popedge_next_accept", {31'd0, tx_drop}, 32'h0);
    bus_read(A_ST, rd);
    check("popedge_status", rd, 32'h0000_1005);

    resetn = 1'b0;
    #1;
    check("burst_reset_line", {31'd0, uart_tx}, 32'h1);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;

    // Mid-frame DIV write, then reset during data bit 3
    bus_write(A_TX, 32'hA3, 4'h1);
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk); #1;
      check($sformatf("frameA3_k%0d", k), {31'd0, uart_tx}, {31'd0, exp_line(8'hA3, k, 4)});
      if (k == 1) begin
        mem_addr = A_DIV; mem_wdata = 32'd9; mem_wstrb = 4'hF; mem_wren = 1'b1;
      end else if (k == 2) begin
        mem_wren = 1'b0; mem_rden = 1'b1;
      end else if (k == 3) begin
        mem_rden = 1'b0;
        check("midframe_div_read", mem_rdata, 32'd9);
      end
    end
    resetn = 1'b0;
    #1;
    check("midreset_line", {31'd0, uart_tx}, 32'h1);
    check("midreset_rdata", mem_rdata, 32'h0);
    check("midreset_drop", {31'd0, tx_drop}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    bus_read(A_ST, rd);
    check("postreset_status", rd, 32'h0000_0002);
    bus_read(A_DIV, rd);
    check("postreset_div", rd, 32'h0000_0004);
    check("postreset_line", {31'd0, uart_tx}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the core data bus, directly downstream of the data-memory port; replaces the simulation-only character-print hook at 0x1000_0000 with real serial output.
- Core byte stores to TXDATA are buffered in a FIFO and serialised as 8N1 frames on uart_tx.
- STATUS and DIV registers are readable, so firmware can poll before writing.

Parameters:
- BASE_ADDR, 32'h1000_0000, base of the 16-byte register window.
- CLK_DIV, 868, reset value of the divisor, in clk cycles per bit.
- FIFO_DEPTH, 16, TX FIFO entries; must be a power of 2, minimum 2.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous, active-low reset
- mem_wren  in  1  data-bus write strobe
- mem_rden  in  1  data-bus read strobe
- mem_addr  in  32  data-bus byte address
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte enables
- mem_rdata  out  32  registered read data
- sel_hit  out  1  combinational: mem_addr[31:4] == BASE_ADDR[31:4]
- uart_tx  out  1  serial line, idle high
- tx_drop  out  1  one-cycle pulse when a TXDATA write is lost because the FIFO is full

Behaviour:
- Clock and reset: clk; resetn asynchronous, active-low.
- Reset values:
  - mem_rdata = 0, uart_tx = 1, tx_drop = 0.
  - DIV = CLK_DIV, FIFO empty, FSM in IDLE.
  - Reset mid-frame aborts the frame and drives the line high immediately; FIFO contents are lost.
- Register map: offset is mem_addr[3:2]; mem_addr[1:0] is ignored.
  - 0 TXDATA: write pushes wdata[7:0] only if wstrb[0]=1; reads return 0.
  - 1 STATUS: read-only. bit0 = fifo_full, bit1 = fifo_empty, bit2 = busy (FSM != IDLE), bits[8+:$clog2(FIFO_DEPTH)+1] = fifo count, all other bits 0.
  - 2 DIV: bits[15:0], read/write. A write requires wstrb[1:0]=2'b11. A written value of 0 is stored as 1.
  - 3: reserved; reads return 0, writes are ignored.
- Bus rules:
  - An access acts only when sel_hit=1; other addresses are ignored and mem_rdata holds its value.
  - If mem_rden and mem_wren are both high, the read takes priority and the write is discarded.
  - Read latency is 1: mem_rdata updates at the posedge that samples mem_rden & sel_hit, then holds until the next read.
- FIFO:
  - Push happens at the posedge sampling a valid TXDATA write when full=0.
  - If full=0 is false (FIFO full), the byte is dropped and tx_drop=1 for exactly the next cycle.
  - Full is evaluated on pre-edge state: a write to a full FIFO is dropped even if a pop occurs on the same edge.
  - Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
  - Simultaneous push and pop with count 1..DEPTH-1 leaves count unchanged.
- Transmit FSM (states IDLE, START, DATA, STOP):
  - IDLE: uart_tx=1. If the FIFO is not empty: pop into shift_reg, latch the current DIV into bit_len, set the cycle counter to bit_len-1, go to START. A byte pushed into an empty FIFO is popped on the following edge.
  - START: uart_tx=0 for bit_len cycles.
  - DATA: 8 bits LSB first, each held for bit_len cycles; the bit index counts 0..7.
  - STOP: uart_tx=1 for bit_len cycles, then IDLE.
  - Frame = 10*bit_len cycles, followed by 1 IDLE cycle before the next START.
  - A DIV write mid-frame takes effect only at the next frame.
  - uart_tx is a registered output, glitch-free.

Test Plan:
- Reset with CLK_DIV=4, then read STATUS -> mem_rdata=32'h0000_0002 one cycle later; uart_tx=1.
- Write 0x55 to TXDATA with DIV=4 -> uart_tx low for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high for 4 cycles. Busy bit is clear after 41 cycles.
- DIV=100, write 18 bytes back-to-back -> first byte in flight, 16 buffered, 18th dropped. tx_drop pulses once. STATUS = 32'h0000_1005 (count 16, full, busy).
- Write 0 to DIV, then read DIV -> 32'h0000_0001. Write 0x0042 with wstrb=4'b0001 -> DIV unchanged.
- Assert mem_rden and mem_wren together at TXDATA -> no push, count stays 0, mem_rdata=0. Write to 0x1000_0010 -> sel_hit=0, no effect.
- Deassert resetn during DATA bit 3 -> uart_tx=1 immediately. After release, STATUS=32'h0000_0002 and DIV=CLK_DIV.
